// File: rtl/rgb_led_pkg.sv
// rtl/rgb_led_pkg.sv - shared constants for the RGB LED scheduler
//
// Purpose: state encoding and colour field layout used by rgb_led_scheduler
// and rr_arbiter.
package rgb_led_pkg;

    localparam int COLOR_W   = 24;

    localparam int COL_R_MSB = 23;
    localparam int COL_R_LSB = 16;
    localparam int COL_G_MSB = 15;
    localparam int COL_G_LSB = 8;
    localparam int COL_B_MSB = 7;
    localparam int COL_B_LSB = 0;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SHOW = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter
//
// Purpose: picks the first asserted request at or after ptr_i (mod NREQ).
// Ports:
//   req_i    in   NREQ  request vector
//   ptr_i    in   2     index searched first
//   enable_i in   1     when low no grant is issued
//   grant_o  out  NREQ  one-hot grant
//   idx_o    out  2     binary index of the grant (0 when none)
module rr_arbiter
    import rgb_led_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [1:0]      ptr_i,
    input  logic            enable_i,
    output logic [NREQ-1:0] grant_o,
    output logic [1:0]      idx_o
);

    // Padded to the maximum of 4 requesters so a 2-bit index always fits.
    logic [3:0] req_pad;
    logic [3:0] grant_pad;
    logic [2:0] cand;
    logic       found;

    assign req_pad = 4'(req_i);
    assign grant_o = grant_pad[NREQ-1:0];

    always_comb begin
        grant_pad = '0;
        idx_o     = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            // ptr_i < NREQ, so one conditional subtraction is a full modulo.
            cand = 3'({1'b0, ptr_i}) + 3'(k);
            if (cand >= 3'(NREQ)) begin
                cand = cand - 3'(NREQ);
            end
            if (enable_i && !found && req_pad[cand[1:0]]) begin
                found                = 1'b1;
                grant_pad[cand[1:0]] = 1'b1;
                idx_o                = cand[1:0];
            end
        end
    end

endmodule

// File: rtl/rgb_led_scheduler.sv
// rtl/rgb_led_scheduler.sv - time-shares one RGB LED between requesters
//
// Purpose: round-robin accepts a colour + hold time, then drives PWM on r/g/b
// for hold*TICK_DIV clock cycles before arbitrating again.
// Ports:
//   clk        in   1               system clock
//   rst        in   1               synchronous reset, active-high
//   req_valid  in   NREQ            request valid per requester
//   req_ready  out  NREQ            one-hot accept while idle
//   req_color  in   NREQ*24         {R,G,B} per requester
//   req_hold   in   NREQ*HOLD_BITS  display time in ticks
//   busy       out  1               high while displaying
//   grant_id   out  2               requester last accepted
//   r, g, b    out  1               registered PWM outputs
module rgb_led_scheduler
    import rgb_led_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int PWM_BITS  = 8,
    parameter int TICK_DIV  = 48000,
    parameter int HOLD_BITS = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*COLOR_W-1:0]   req_color,
    input  logic [NREQ*HOLD_BITS-1:0] req_hold,
    output logic                      busy,
    output logic [1:0]                grant_id,
    output logic                      r,
    output logic                      g,
    output logic                      b
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    logic [0:0]           state_q,    state_d;
    logic [1:0]           rr_ptr_q,   rr_ptr_d;
    logic [1:0]           grant_id_q, grant_id_d;
    logic [HOLD_BITS-1:0] hold_cnt_q, hold_cnt_d;
    logic [PRE_W-1:0]     presc_q,    presc_d;
    logic [PWM_BITS-1:0]  pwm_cnt_q,  pwm_cnt_d;
    logic [PWM_BITS-1:0]  duty_r_q,   duty_r_d;
    logic [PWM_BITS-1:0]  duty_g_q,   duty_g_d;
    logic [PWM_BITS-1:0]  duty_b_q,   duty_b_d;
    logic                 r_q, r_d;
    logic                 g_q, g_d;
    logic                 b_q, b_d;

    logic [NREQ-1:0]      gnt;
    logic [1:0]           gnt_idx;
    logic                 accept;
    logic [COLOR_W-1:0]   sel_color;
    logic [HOLD_BITS-1:0] sel_hold;
    logic [1:0]           next_ptr;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req_i    (req_valid),
        .ptr_i    (rr_ptr_q),
        .enable_i (state_q == ST_IDLE),
        .grant_o  (gnt),
        .idx_o    (gnt_idx)
    );

    assign req_ready = gnt;
    assign accept    = |(req_valid & gnt);
    assign next_ptr  = (gnt_idx == 2'(NREQ - 1)) ? 2'd0 : gnt_idx + 2'd1;

    assign busy      = (state_q == ST_SHOW);
    assign grant_id  = grant_id_q;
    assign r         = r_q;
    assign g         = g_q;
    assign b         = b_q;

    // Grant is one-hot, so at most one slice is selected.
    always_comb begin
        sel_color = '0;
        sel_hold  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_color = req_color[i*COLOR_W +: COLOR_W];
                sel_hold  = req_hold[i*HOLD_BITS +: HOLD_BITS];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        hold_cnt_d = hold_cnt_q;
        presc_d    = presc_q;
        pwm_cnt_d  = pwm_cnt_q;
        duty_r_d   = duty_r_q;
        duty_g_d   = duty_g_q;
        duty_b_d   = duty_b_q;

        // Outputs are compared against the current counter, so they lag state by one cycle.
        r_d = (state_q == ST_SHOW) && (pwm_cnt_q < duty_r_q);
        g_d = (state_q == ST_SHOW) && (pwm_cnt_q < duty_g_q);
        b_d = (state_q == ST_SHOW) && (pwm_cnt_q < duty_b_q);

        if (state_q == ST_IDLE) begin
            if (accept) begin
                duty_r_d   = PWM_BITS'(sel_color[COL_R_MSB:COL_R_LSB]);
                duty_g_d   = PWM_BITS'(sel_color[COL_G_MSB:COL_G_LSB]);
                duty_b_d   = PWM_BITS'(sel_color[COL_B_MSB:COL_B_LSB]);
                hold_cnt_d = sel_hold;
                presc_d    = '0;
                pwm_cnt_d  = '0;
                grant_id_d = gnt_idx;
                rr_ptr_d   = next_ptr;
                // A zero hold consumes the request without displaying it.
                state_d    = (sel_hold != '0) ? ST_SHOW : ST_IDLE;
            end
        end else begin
            pwm_cnt_d = pwm_cnt_q + 1'b1;
            if (presc_q == PRE_MAX) begin
                presc_d    = '0;
                hold_cnt_d = hold_cnt_q - 1'b1;
                if (hold_cnt_q == HOLD_BITS'(1)) begin
                    state_d = ST_IDLE;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            hold_cnt_q <= '0;
            presc_q    <= '0;
            pwm_cnt_q  <= '0;
            duty_r_q   <= '0;
            duty_g_q   <= '0;
            duty_b_q   <= '0;
            r_q        <= 1'b0;
            g_q        <= 1'b0;
            b_q        <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            hold_cnt_q <= hold_cnt_d;
            presc_q    <= presc_d;
            pwm_cnt_q  <= pwm_cnt_d;
            duty_r_q   <= duty_r_d;
            duty_g_q   <= duty_g_d;
            duty_b_q   <= duty_b_d;
            r_q        <= r_d;
            g_q        <= g_d;
            b_q        <= b_d;
        end
    end

endmodule
